// File: rtl/add_constant_checker.sv
// Receive-side checker for constant-stride arithmetic streams: learns base and
// stride from the first two valid samples, then flags every deviating sample.
module add_constant_checker #(
  parameter int unsigned W          = 32,
  parameter int unsigned ERR_W      = 16,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_vld,
  input  logic [W-1:0]     in_data,
  output logic             locked,
  output logic [W-1:0]     base,
  output logic [W-1:0]     stride,
  output logic             mismatch,
  output logic [W-1:0]     mis_exp,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HAVE_BASE,
    LOCKED
  } state_t;

  state_t       state;
  logic [W-1:0] prev;
  logic [7:0]   miss_run;

  logic [W-1:0] exp_val;
  logic         last_miss;
  logic         err_full;

  always_comb begin
    exp_val   = prev + stride;
    last_miss = (miss_run == 8'(MISS_LIMIT - 1));
    err_full  = &err_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= '0;
      miss_run <= '0;
      locked   <= 1'b0;
      base     <= '0;
      stride   <= '0;
      mismatch <= 1'b0;
      mis_exp  <= '0;
      err_cnt  <= '0;
    end else if (clear) begin
      state    <= IDLE;
      prev     <= '0;
      miss_run <= '0;
      locked   <= 1'b0;
      base     <= '0;
      stride   <= '0;
      mismatch <= 1'b0;
      mis_exp  <= '0;
      err_cnt  <= '0;
    end else begin
      mismatch <= 1'b0;
      if (in_vld) begin
        case (state)
          IDLE: begin
            base  <= in_data;
            prev  <= in_data;
            state <= HAVE_BASE;
          end
          HAVE_BASE: begin
            stride   <= in_data - prev;
            prev     <= in_data;
            miss_run <= '0;
            locked   <= 1'b1;
            state    <= LOCKED;
          end
          LOCKED: begin
            if (in_data == exp_val) begin
              prev     <= in_data;
              miss_run <= '0;
            end else begin
              mismatch <= 1'b1;
              mis_exp  <= exp_val;
              if (!err_full) err_cnt <= err_cnt + 1'b1;
              // Prediction keeps advancing on a bad sample; only a run of
              // MISS_LIMIT bad samples restarts learning from the current one.
              if (last_miss) begin
                locked   <= 1'b0;
                state    <= HAVE_BASE;
                base     <= in_data;
                prev     <= in_data;
                miss_run <= '0;
              end else begin
                prev     <= exp_val;
                miss_run <= miss_run + 8'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_add_constant_checker.sv
// Self-checking bench for add_constant_checker: directed spec scenarios plus a
// randomized stream checked against a sample-index based reference model.
module tb_add_constant_checker;

  localparam int unsigned W     = 32;
  localparam int unsigned LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst, clear, in_vld;
  logic [31:0] in_data;

  logic        locked, mismatch;
  logic [31:0] base, stride, mis_exp;
  logic [15:0] err_cnt;

  logic        s_locked, s_mismatch;
  logic [31:0] s_base, s_stride, s_mis_exp;
  logic [1:0]  s_err_cnt;

  add_constant_checker #(.W(W), .ERR_W(16), .MISS_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_vld(in_vld), .in_data(in_data),
    .locked(locked), .base(base), .stride(stride), .mismatch(mismatch),
    .mis_exp(mis_exp), .err_cnt(err_cnt)
  );

  add_constant_checker #(.W(W), .ERR_W(2), .MISS_LIMIT(LIMIT)) dut_small (
    .clk(clk), .rst(rst), .clear(clear), .in_vld(in_vld), .in_data(in_data),
    .locked(s_locked), .base(s_base), .stride(s_stride), .mismatch(s_mismatch),
    .mis_exp(s_mis_exp), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: n = number of samples taken in the current lock attempt;
  // the k-th sample of an attempt (k>=2) must equal base + k*stride.
  int unsigned m_n, m_run, m_err;
  logic [31:0] m_base, m_stride, m_misexp;
  logic        m_locked, m_mis;

  function automatic void model_reset();
    m_n = 0; m_run = 0; m_err = 0;
    m_base = '0; m_stride = '0; m_misexp = '0;
    m_locked = 1'b0; m_mis = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic [31:0] d, input logic c);
    logic [31:0] e;
    m_mis = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if (m_n == 0) begin
        m_base = d; m_n = 1;
      end else if (m_n == 1) begin
        m_stride = d - m_base; m_n = 2; m_locked = 1'b1; m_run = 0;
      end else begin
        e = m_base + m_n * m_stride;
        if (d == e) begin
          m_n++; m_run = 0;
        end else begin
          m_mis = 1'b1; m_misexp = e; m_err++; m_run++;
          if (m_run == LIMIT) begin
            m_locked = 1'b0; m_base = d; m_n = 1; m_run = 0;
          end else begin
            m_n++;
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned sat_big, sat_small;
    sat_big   = (m_err > 65535) ? 65535 : m_err;
    sat_small = (m_err > 3) ? 3 : m_err;
    check({tag, ".locked"},   64'(locked),    64'(m_locked));
    check({tag, ".base"},     64'(base),      64'(m_base));
    check({tag, ".stride"},   64'(stride),    64'(m_stride));
    check({tag, ".mismatch"}, 64'(mismatch),  64'(m_mis));
    check({tag, ".mis_exp"},  64'(mis_exp),   64'(m_misexp));
    check({tag, ".err_cnt"},  64'(err_cnt),   64'(sat_big));
    check({tag, ".err_sat"},  64'(s_err_cnt), 64'(sat_small));
    check({tag, ".s_locked"}, 64'(s_locked),  64'(m_locked));
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] d, input logic c);
    @(negedge clk);
    in_vld = v; in_data = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    check_all(tag);
    in_vld = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    step("clear", 1'b0, 32'd0, 1'b1);
  endtask

  int unsigned mis_seen;

  initial begin
    logic [31:0] g_base, g_stride, g_idx, d;
    logic        v, c;
    rst = 1'b1; clear = 1'b0; in_vld = 1'b0; in_data = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst = 1'b0;

    // Basic lock
    step("lock0", 1'b1, 32'd5, 1'b0);
    check("lock0_unlocked", 64'(locked), 64'd0);
    step("lock1", 1'b1, 32'd12, 1'b0);
    check("lock1_locked", 64'(locked), 64'd1);
    check("lock1_stride", 64'(stride), 64'd7);
    step("lock2", 1'b1, 32'd19, 1'b0);
    step("lock3", 1'b1, 32'd26, 1'b0);
    check("lock_base", 64'(base), 64'd5);
    check("lock_err", 64'(err_cnt), 64'd0);

    // Wrap-around
    do_clear();
    step("wrap0", 1'b1, 32'hFFFF_FFFE, 1'b0);
    step("wrap1", 1'b1, 32'h0000_0001, 1'b0);
    step("wrap2", 1'b1, 32'h0000_0004, 1'b0);
    check("wrap_stride", 64'(stride), 64'd3);
    check("wrap_nomis", 64'(mismatch), 64'd0);

    // Single corruption
    do_clear();
    step("sc0", 1'b1, 32'd10, 1'b0);
    step("sc1", 1'b1, 32'd20, 1'b0);
    step("sc2", 1'b1, 32'd30, 1'b0);
    step("sc3", 1'b1, 32'd99, 1'b0);
    check("sc_pulse", 64'(mismatch), 64'd1);
    check("sc_misexp", 64'(mis_exp), 64'd40);
    check("sc_err", 64'(err_cnt), 64'd1);
    step("sc4", 1'b1, 32'd50, 1'b0);
    check("sc_pass", 64'(mismatch), 64'd0);
    check("sc_locked", 64'(locked), 64'd1);

    // Loss of lock and relock
    do_clear();
    step("ll0", 1'b1, 32'd10, 1'b0);
    step("ll1", 1'b1, 32'd20, 1'b0);
    step("ll2", 1'b1, 32'd7, 1'b0);
    check("ll_misexp1", 64'(mis_exp), 64'd30);
    step("ll3", 1'b1, 32'd7, 1'b0);
    check("ll_misexp2", 64'(mis_exp), 64'd40);
    step("ll4", 1'b1, 32'd7, 1'b0);
    check("ll_misexp3", 64'(mis_exp), 64'd50);
    check("ll_unlock", 64'(locked), 64'd0);
    check("ll_base", 64'(base), 64'd7);
    check("ll_err", 64'(err_cnt), 64'd3);
    step("ll5", 1'b1, 32'd9, 1'b0);
    check("ll_relock", 64'(locked), 64'd1);
    check("ll_stride", 64'(stride), 64'd2);
    step("ll6", 1'b1, 32'd11, 1'b0);
    check("ll_pass", 64'(mismatch), 64'd0);

    // Gaps, then clear with a same-cycle sample, then stride 0
    do_clear();
    step("gap0", 1'b1, 32'd5, 1'b0);
    for (int i = 0; i < 3; i++) step("gapb", 1'b0, 32'hDEAD, 1'b0);
    step("gap1", 1'b1, 32'd12, 1'b0);
    step("gapb", 1'b0, 32'hBEEF, 1'b0);
    step("gap2", 1'b1, 32'd19, 1'b0);
    check("gap_stride", 64'(stride), 64'd7);
    check("gap_err", 64'(err_cnt), 64'd0);
    step("clrv", 1'b1, 32'd0, 1'b1);
    check("clr_locked", 64'(locked), 64'd0);
    check("clr_base", 64'(base), 64'd0);
    step("z0", 1'b1, 32'd100, 1'b0);
    step("z1", 1'b1, 32'd100, 1'b0);
    check("z_stride", 64'(stride), 64'd0);
    check("z_locked", 64'(locked), 64'd1);

    // Six mismatches: narrow counter saturates at 3
    do_clear();
    step("sat", 1'b1, 32'd0, 1'b0);
    step("sat", 1'b1, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) step("sat", 1'b1, 32'd50, 1'b0);
    for (int i = 0; i < 3; i++) step("sat", 1'b1, 32'd9, 1'b0);
    check("sat_small", 64'(s_err_cnt), 64'd3);
    check("sat_big", 64'(err_cnt), 64'd6);

    // Asynchronous reset between edges while locked
    step("ar", 1'b1, 32'd40, 1'b0);
    step("ar", 1'b1, 32'd44, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;

    // Randomized generator streams with bubbles, corruption and clears
    mis_seen = 0;
    g_base = $urandom; g_stride = $urandom; g_idx = 0;
    for (int i = 0; i < 1500; i++) begin
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 79) == 0) begin
        g_base = $urandom; g_idx = 0;
        g_stride = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      end
      d = g_base + g_idx * g_stride;
      if (v && $urandom_range(0, 9) == 0) d = d ^ ($urandom | 32'd1);
      if (v && !c) g_idx++;
      step("rand", v, d, c);
      if (m_mis) mis_seen++;
    end
    check("rand_saw_mismatch", 64'(mis_seen > 0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
